// File: rtl/dac7611_scheduler.sv
// dac7611_scheduler: round-robin arbiter for four requesters sharing one
// DAC7611 serial DAC. Each granted code is shifted MSB first at clk/4,
// latched with an active-low LD pulse, and followed by a short idle gap.
// Clear requests are sticky and serviced whenever the DAC falls idle.
module dac7611_scheduler #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned GAP     = 2,
    parameter int unsigned CLR_CYC = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [12*NREQ-1:0]   req_data,
    output logic [NREQ-1:0]      req_ready,
    input  logic                 clr_req,
    output logic                 busy,
    output logic [1:0]           grant_id,
    output logic                 dac_clk,
    output logic                 dac_sdi,
    output logic                 dac_ld,
    output logic                 dac_clr_n
);

    localparam int unsigned DW        = 12;
    localparam int unsigned CW        = 6;
    localparam int unsigned IDW       = 2;
    localparam int unsigned SHIFT_CYC = 48;
    localparam int unsigned LOAD_CYC  = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT,
        S_LOAD,
        S_GAP,
        S_CLEAR
    } state_t;

    state_t             r_state;
    logic [CW-1:0]      r_cnt;
    logic [DW-1:0]      r_data;
    logic [IDW-1:0]     r_ptr;
    logic               r_pending;
    logic [NREQ-1:0]    r_req_ready;
    logic [IDW-1:0]     r_grant_id;
    logic               r_busy;
    logic               r_dac_clk;
    logic               r_dac_sdi;
    logic               r_dac_ld;
    logic               r_dac_clr_n;

    state_t             w_state;
    logic [CW-1:0]      w_cnt;
    logic [DW-1:0]      w_data;
    logic [IDW-1:0]     w_ptr;
    logic               w_pending;
    logic [NREQ-1:0]    w_req_ready;
    logic [IDW-1:0]     w_grant_id;
    logic               w_busy;
    logic               w_dac_clk;
    logic               w_dac_sdi;
    logic               w_dac_ld;
    logic               w_dac_clr_n;
    logic               w_arb;
    logic               w_clr_any;

    logic               w_arb_found;
    logic [IDW-1:0]     w_arb_idx;
    logic [IDW-1:0]     w_cand;

    // Round-robin search for the first asserted requester starting at the pointer.
    always_comb begin
        w_arb_found = 1'b0;
        w_arb_idx   = r_ptr;
        w_cand      = r_ptr;
        for (int k = 0; k < NREQ; k++) begin
            w_cand = r_ptr + IDW'(k);
            if (!w_arb_found && req_valid[w_cand]) begin
                w_arb_found = 1'b1;
                w_arb_idx   = w_cand;
            end
        end
    end

    // Next-state logic; DAC pin levels are derived from the next state so that
    // the registered outputs line up with the state they belong to.
    always_comb begin
        w_state     = r_state;
        w_cnt       = r_cnt + CW'(1);
        w_data      = r_data;
        w_ptr       = r_ptr;
        w_clr_any   = r_pending | clr_req;
        w_pending   = w_clr_any;
        w_req_ready = '0;
        w_grant_id  = r_grant_id;
        w_arb       = 1'b0;
        w_busy      = 1'b0;
        w_dac_clk   = 1'b1;
        w_dac_sdi   = 1'b0;
        w_dac_ld    = 1'b1;
        w_dac_clr_n = 1'b1;

        case (r_state)
            S_IDLE: begin
                // A non-zero ready pulse marks the grant cycle; the frame starts next.
                if (|r_req_ready) begin
                    w_state = S_SHIFT;
                    w_cnt   = '0;
                end else begin
                    w_arb = 1'b1;
                end
            end
            S_SHIFT: begin
                if (r_cnt == CW'(SHIFT_CYC - 1)) begin
                    w_state = S_LOAD;
                    w_cnt   = '0;
                end
            end
            S_LOAD: begin
                if (r_cnt == CW'(LOAD_CYC - 1)) begin
                    if (GAP == 0) begin
                        w_arb = 1'b1;
                    end else begin
                        w_state = S_GAP;
                        w_cnt   = '0;
                    end
                end
            end
            S_GAP: begin
                if (r_cnt == CW'(GAP - 1)) begin
                    w_arb = 1'b1;
                end
            end
            S_CLEAR: begin
                if (r_cnt == CW'(CLR_CYC - 1)) begin
                    w_arb = 1'b1;
                end
            end
            default: begin
                w_state = S_IDLE;
                w_cnt   = '0;
            end
        endcase

        // Whenever the DAC becomes free: clear first, otherwise grant a requester.
        if (w_arb) begin
            w_state = S_IDLE;
            w_cnt   = '0;
            if (w_clr_any) begin
                w_state   = S_CLEAR;
                w_pending = 1'b0;
            end else if (w_arb_found) begin
                w_req_ready = NREQ'(1) << w_arb_idx;
                w_grant_id  = w_arb_idx;
                w_ptr       = w_arb_idx + IDW'(1);
                w_data      = req_data[DW*w_arb_idx +: DW];
            end
        end

        w_busy = (w_state != S_IDLE);
        case (w_state)
            S_SHIFT: begin
                w_dac_clk = w_cnt[1];
                w_dac_sdi = w_data[4'(DW - 1) - w_cnt[5:2]];
            end
            S_LOAD:  w_dac_ld    = ~w_cnt[1];
            S_CLEAR: w_dac_clr_n = 1'b0;
            default: ;
        endcase
    end

    // State and output registers; reset forces idle pin levels at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_data      <= '0;
            r_ptr       <= '0;
            r_pending   <= 1'b0;
            r_req_ready <= '0;
            r_grant_id  <= '0;
            r_busy      <= 1'b0;
            r_dac_clk   <= 1'b1;
            r_dac_sdi   <= 1'b0;
            r_dac_ld    <= 1'b1;
            r_dac_clr_n <= 1'b1;
        end else begin
            r_state     <= w_state;
            r_cnt       <= w_cnt;
            r_data      <= w_data;
            r_ptr       <= w_ptr;
            r_pending   <= w_pending;
            r_req_ready <= w_req_ready;
            r_grant_id  <= w_grant_id;
            r_busy      <= w_busy;
            r_dac_clk   <= w_dac_clk;
            r_dac_sdi   <= w_dac_sdi;
            r_dac_ld    <= w_dac_ld;
            r_dac_clr_n <= w_dac_clr_n;
        end
    end

    assign req_ready = r_req_ready;
    assign busy      = r_busy;
    assign grant_id  = r_grant_id;
    assign dac_clk   = r_dac_clk;
    assign dac_sdi   = r_dac_sdi;
    assign dac_ld    = r_dac_ld;
    assign dac_clr_n = r_dac_clr_n;

endmodule

// File: tb/tb_dac7611_scheduler.sv
// Testbench for dac7611_scheduler: directed scenarios plus randomized rounds.
// The driver predicts frame/clear order with a round-robin model and pushes it
// into a queue; the monitor decodes the DAC pins and pops/compares.
module tb_dac7611_scheduler;

    localparam int GAP     = 2;
    localparam int CLR_CYC = 2;
    localparam int FRAME   = 1 + 48 + 4 + GAP;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [47:0] req_data = '0;
    logic        clr_req = 1'b0;
    logic [3:0]  req_ready;
    logic        busy;
    logic [1:0]  grant_id;
    logic        dac_clk, dac_sdi, dac_ld, dac_clr_n;

    dac7611_scheduler #(.NREQ(4), .GAP(GAP), .CLR_CYC(CLR_CYC)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .clr_req(clr_req), .busy(busy), .grant_id(grant_id),
        .dac_clk(dac_clk), .dac_sdi(dac_sdi), .dac_ld(dac_ld), .dac_clr_n(dac_clr_n)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       is_clr;
        bit [1:0] id;
        bit [11:0] data;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_errors = 0;

    // Driver-side control, read by the monitor.
    int  tmo_cnt = 0;
    bit  chk_period = 0;
    bit  chk_clr_gap = 0;
    bit  final_chk = 0;
    bit  final_done = 0;
    bit  auto_drop = 1;

    logic [11:0] dat [4];
    int          m_ptr = 0;

    // ------------------------------------------------------------------ monitor
    int        cyc = 0;
    int        tmo_seen = 0;
    bit        in_frame = 0;
    int        fcyc = 0;
    int        bits = 0;
    logic [11:0] got = '0;
    int        g_id = 0;
    bit        ld_bad = 0;
    logic      prev_clk = 1'b1;
    logic      prev_clr = 1'b1;
    int        clr_len = 0;
    int        last_grant = 0;
    bit        last_was_period = 0;

    task automatic chk(input string name, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (tmo_cnt != tmo_seen) begin
            tmo_seen++;
            chk("wait_timeout", 1, 0);
        end
        if (!reset) begin
            chk("reset_idle_levels",
                int'({req_ready, busy, grant_id, dac_clk, dac_sdi, dac_ld, dac_clr_n}),
                int'(11'b0000_0_00_1011));
            in_frame = 0;
            clr_len = 0;
            prev_clk = 1'b1;
            prev_clr = 1'b1;
            last_was_period = 0;
            exp_q.delete();
        end else begin
            if (req_ready != 4'b0) begin
                chk("ready_onehot", int'($onehot(req_ready)), 1);
                chk("busy_in_grant_cycle", int'(busy), 0);
                if (chk_period && last_was_period)
                    chk("grant_period", cyc - last_grant, FRAME);
                last_was_period = chk_period;
                last_grant = cyc;
                for (int i = 0; i < 4; i++) if (req_ready[i]) g_id = i;
                in_frame = 1;
                fcyc = 0;
                bits = 0;
                got = '0;
                ld_bad = 0;
            end else if (in_frame) begin
                fcyc++;
                if (fcyc == 1) chk("busy_after_grant", int'(busy), 1);
                if (!prev_clk && dac_clk) begin
                    got = {got[10:0], dac_sdi};
                    bits++;
                end
                if (dac_ld != !(fcyc == 51 || fcyc == 52)) ld_bad = 1;
                if (fcyc == 52) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_frame_from", g_id, 255);
                    end else begin
                        e = exp_q.pop_front();
                        chk("frame_vs_clear_order", 0, int'(e.is_clr));
                        chk("frame_ready_id", g_id, int'(e.id));
                        chk("frame_grant_id", int'(grant_id), int'(e.id));
                        chk("frame_bit_count", bits, 12);
                        chk("frame_data", int'(got), int'(e.data));
                    end
                end
                if (fcyc == 54) begin
                    chk("ld_pulse_timing", int'(ld_bad), 0);
                    in_frame = 0;
                end
            end
            if (!dac_clr_n) begin
                if (prev_clr && chk_clr_gap)
                    chk("clear_after_gap", cyc - last_grant, FRAME);
                clr_len++;
            end else if (!prev_clr) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_clear_len", clr_len, 255);
                end else begin
                    e = exp_q.pop_front();
                    chk("clear_vs_frame_order", 1, int'(e.is_clr));
                    chk("clear_length", clr_len, CLR_CYC);
                end
                clr_len = 0;
            end
            prev_clk = dac_clk;
            prev_clr = dac_clr_n;
        end
        if (final_chk && !final_done) begin
            chk("leftover_expectations", exp_q.size(), 0);
            final_done = 1;
        end
    end

    // ------------------------------------------------------------------- driver
    task automatic push_g(input int id);
        exp_t e;
        e.is_clr = 0;
        e.id = 2'(id);
        e.data = dat[id];
        exp_q.push_back(e);
    endtask

    task automatic push_c();
        exp_t e;
        e.is_clr = 1;
        e.id = 2'd0;
        e.data = 12'd0;
        exp_q.push_back(e);
    endtask

    // Clear first if requested, then held requesters in round-robin order from m_ptr.
    task automatic model_round(input logic [3:0] mask, input bit clr);
        int last;
        last = -1;
        if (clr) push_c();
        for (int k = 0; k < 4; k++) begin
            int id;
            id = (m_ptr + k) % 4;
            if (mask[id]) begin
                push_g(id);
                last = id;
            end
        end
        if (last >= 0) m_ptr = (last + 1) % 4;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        clr_req = 1'b0;
        if (auto_drop) req_valid = req_valid & ~req_ready;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic drive_data();
        req_data = {dat[3], dat[2], dat[1], dat[0]};
    endtask

    task automatic wait_drained(input int budget);
        int n;
        n = 0;
        while (req_valid != 4'b0 && n < budget) begin
            tick();
            n++;
        end
        if (req_valid != 4'b0) begin
            tmo_cnt++;
            req_valid = 4'b0;
        end
    endtask

    task automatic wait_quiet();
        int quiet;
        int n;
        quiet = 0;
        n = 0;
        while (quiet < 4 && n < 400) begin
            tick();
            n++;
            if (!busy && req_ready == 4'b0) quiet++;
            else quiet = 0;
        end
        if (quiet < 4) tmo_cnt++;
    endtask

    task automatic issue(input logic [3:0] mask, input bit clr);
        model_round(mask, clr);
        drive_data();
        req_valid = mask;
        clr_req = clr;
        tick();
    endtask

    initial begin
        int n;
        int grants;
        logic [3:0] mask;
        bit clr;

        for (int i = 0; i < 4; i++) dat[i] = 12'd0;
        #2 reset = 1'b0;
        ticks(3);
        reset = 1'b1;
        ticks(2);

        // All four held: grants 0,1,2,3,0 at FRAME-cycle spacing.
        for (int i = 0; i < 4; i++) dat[i] = 12'($urandom_range(0, 4095));
        drive_data();
        for (int i = 0; i < 5; i++) begin
            push_g(m_ptr);
            m_ptr = (m_ptr + 1) % 4;
        end
        auto_drop = 0;
        chk_period = 1;
        req_valid = 4'b1111;
        grants = 0;
        n = 0;
        while (grants < 5 && n < 400) begin
            tick();
            n++;
            if (req_ready != 4'b0) grants++;
        end
        req_valid = 4'b0;
        if (grants < 5) tmo_cnt++;
        auto_drop = 1;
        wait_quiet();
        chk_period = 0;

        // Single requester 2 with a known code.
        dat[2] = 12'hA5C;
        issue(4'b0100, 0);
        wait_drained(100);
        wait_quiet();

        // Clear and requester 1 in the same idle cycle: clear wins.
        dat[1] = 12'($urandom_range(0, 4095));
        issue(4'b0010, 1);
        wait_drained(100);
        wait_quiet();

        // One-cycle request from 0 while busy is lost.
        dat[3] = 12'($urandom_range(0, 4095));
        issue(4'b1000, 0);
        ticks(10);
        dat[0] = 12'($urandom_range(0, 4095));
        drive_data();
        req_valid = 4'b0001;
        tick();
        req_valid = 4'b0000;
        wait_quiet();

        // Clear during shift bit 5 waits for the frame and gap to finish.
        dat[2] = 12'($urandom_range(0, 4095));
        chk_clr_gap = 1;
        issue(4'b0100, 0);
        ticks(22);
        push_c();
        clr_req = 1'b1;
        tick();
        wait_quiet();
        chk_clr_gap = 0;

        // Randomized rounds.
        for (int r = 0; r < 12; r++) begin
            for (int i = 0; i < 4; i++) dat[i] = 12'($urandom_range(0, 4095));
            mask = 4'($urandom_range(1, 15));
            clr = ($urandom_range(0, 3) == 0);
            issue(mask, clr);
            wait_drained(600);
            wait_quiet();
        end

        // Reset mid-frame, then only requester 3 after release.
        dat[1] = 12'($urandom_range(0, 4095));
        drive_data();
        req_valid = 4'b0010;
        tick();
        ticks(26);
        reset = 1'b0;
        req_valid = 4'b0;
        ticks(3);
        reset = 1'b1;
        m_ptr = 0;
        dat[3] = 12'($urandom_range(0, 4095));
        issue(4'b1000, 0);
        wait_drained(100);
        wait_quiet();

        final_chk = 1;
        n = 0;
        while (!final_done && n < 10) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dac7611_scheduler.md
DAC7611_SCHEDULER -- requirements
Module: dac7611_scheduler

Interface
REQ-001 Parameter: NREQ, 4, number of requesters (fixed at 4 in this revision).
REQ-002 Parameter: GAP, 2, idle clk cycles inserted after each LD pulse before the next frame (range 0-15).
REQ-003 Parameter: CLR_CYC, 2, clk cycles dac_clr_n is held low per clear (range 2-15).
REQ-004 clk  in  1  system clock; DAC serial clock runs at clk/4 (2 clk cycles per half period).
REQ-005 reset  in  1  asynchronous, active-low.
REQ-006 req_valid  in  4  per-requester write request (level).
REQ-007 req_data  in  48  requester i code at bits [12i+11:12i]; stable while req_valid[i]=1.
REQ-008 req_ready  out  4  one-hot, single-cycle acceptance pulse.
REQ-009 clr_req  in  1  single-cycle clear request pulse.
REQ-010 busy  out  1  high whenever state is not IDLE.
REQ-011 grant_id  out  2  index of the requester owning the current or last frame.
REQ-012 dac_clk, dac_sdi, dac_ld, dac_clr_n  out  1 each  DAC7611 CLK, SDI, LD (active-low load), CLR (active-low).

Function
REQ-013 States: IDLE, SHIFT, LOAD, GAP, CLEAR; all DAC outputs and req_ready SHALL be registered.
REQ-014 Idle levels: dac_clk=1, dac_sdi=0, dac_ld=1, dac_clr_n=1.
REQ-015 clr_req SHALL set a sticky clr_pending bit; clr_pending is cleared on entry to CLEAR.
REQ-016 In IDLE with clr_pending=1: enter CLEAR next cycle regardless of req_valid (clear has priority).
REQ-017 In IDLE with clr_pending=0 and any req_valid: grant the first asserted requester searching round-robin from (last grant+1) mod 4; pointer after reset starts the search at 0.
REQ-018 Grant cycle: req_ready[i]=1 for exactly that cycle, req_data slice latched, grant_id updated, state -> SHIFT.
REQ-019 SHIFT: 12 bits MSB first, 4 cycles per bit; dac_clk low for cycles 0-1, high for cycles 2-3 of each bit; dac_sdi driven with the bit for all 4 cycles; SHIFT lasts exactly 48 cycles.
REQ-020 First dac_clk low SHALL appear on the cycle after the grant cycle.
REQ-021 LOAD: 4 cycles; dac_ld high for cycles 0-1, low for cycles 2-3; dac_clk=1, dac_sdi=0.
REQ-022 GAP: GAP cycles at idle levels, then IDLE; GAP=0 returns to IDLE directly from LOAD.
REQ-023 Frame length grant-to-IDLE SHALL be 1+48+4+GAP cycles; busy=1 from the cycle after grant through the last GAP cycle.
REQ-024 CLEAR: dac_clr_n low for CLR_CYC cycles, other outputs idle, then IDLE; round-robin pointer unchanged.
REQ-025 clr_req arriving during SHIFT/LOAD/GAP SHALL NOT abort the frame; it is serviced at the next IDLE.
REQ-026 clr_req arriving during CLEAR SHALL be retained and produce a second clear.
REQ-027 Requester deasserting req_valid before its grant SHALL lose the request with no side effect.
REQ-028 Bit counter SHALL wrap only via state transition; no partial frame is ever emitted.

Reset
REQ-029 reset low SHALL immediately force idle levels on DAC outputs, req_ready=0, busy=0, grant_id=0, clr_pending=0, pointer=0, state=IDLE, including mid-frame.
REQ-030 After reset release, the first grant SHALL occur no earlier than the first clk edge with reset high.

Verification
REQ-031 req_valid[2]=1, data 0xA5C -> req_ready[2] one cycle, sdi bits 1010_0101_1100 sampled on dac_clk rising edges, dac_ld low cycles 51-52 after grant.
REQ-032 req_valid=4'b1111 held -> grants 0,1,2,3,0 in order, each frame 55 cycles apart with GAP=2.
REQ-033 clr_req and req_valid[1] in same IDLE cycle -> dac_clr_n low 2 cycles, then grant to requester 1.
REQ-034 clr_req at SHIFT bit 5 -> frame completes unchanged, dac_clr_n pulse follows the GAP.
REQ-035 reset asserted at SHIFT bit 6 -> all outputs at idle levels immediately; after release, req_valid[3] -> grant 3 (search starts at 0, only 3 valid).
REQ-036 req_valid[0] pulsed for 1 cycle while busy -> no req_ready[0], no frame for requester 0.
